// File: rtl/dual_edge_deser.sv
// Dual-edge capture deserialiser: samples a DATA_WIDTH bus on both clock edges and packs
// RATIO samples per word behind a valid/ready register. Optional counters: DUAL_EDGE_DESER_STATS_EN.
module dual_edge_deser #(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic [DATA_WIDTH-1:0]         pos_edge_latch_en,
   input  logic [DATA_WIDTH-1:0]         neg_edge_latch_en,
   output logic [DATA_WIDTH*RATIO-1:0]   data_out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          overflow
`ifdef DUAL_EDGE_DESER_STATS_EN
   ,
   output logic [15:0]                   word_cnt,
   output logic [15:0]                   drop_cnt
`endif
);

   localparam int PAIRS  = RATIO / 2;
   localparam int PAIR_W = 2 * DATA_WIDTH;
   localparam int WORD_W = DATA_WIDTH * RATIO;
   localparam int IDX_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;

   if (DATA_WIDTH < 1) begin : g_bad_width
      $error("dual_edge_deser: DATA_WIDTH must be at least 1");
   end
   if ((RATIO < 2) || ((RATIO % 2) != 0)) begin : g_bad_ratio
      $error("dual_edge_deser: RATIO must be even and at least 2");
   end

   // Per-bit enable: enabled bits take the new data, disabled bits repeat their last capture.
   function automatic logic [DATA_WIDTH-1:0] gated_load(
      input logic [DATA_WIDTH-1:0] old_val,
      input logic [DATA_WIDTH-1:0] new_val,
      input logic [DATA_WIDTH-1:0] en
   );
      return (new_val & en) | (old_val & ~en);
   endfunction

   logic [DATA_WIDTH-1:0]    pos_hold;
   logic [DATA_WIDTH-1:0]    neg_hold;
   logic [DATA_WIDTH-1:0]    pos_next;
   logic [DATA_WIDTH-1:0]    pos_snap_p0;
   logic                     pend_p0;
   logic [IDX_W-1:0]         pair_idx;
   logic [WORD_W-1:0]        asm_q;
   logic [PAIR_W-1:0]        pair_word;
   logic [WORD_W+PAIR_W-1:0] asm_cat;
   logic [WORD_W-1:0]        word_next;
   logic                     word_done;
   logic                     word_load;
   logic                     word_drop;

   assign pos_next = gated_load(pos_hold, data_in, pos_edge_latch_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_hold <= '0;
      end else begin
         pos_hold <= pos_next;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_hold <= '0;
      end else begin
         neg_hold <= gated_load(neg_hold, data_in, neg_edge_latch_en);
      end
   end

   // Stage p0: qualified posedge sample waits one cycle for its negedge partner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_p0     <= 1'b0;
         pos_snap_p0 <= '0;
      end else begin
         pend_p0 <= in_valid;
         if (in_valid) begin
            pos_snap_p0 <= pos_next;
         end
      end
   end

   // Shift right by one pair so the earliest pair lands in the lowest slice after PAIRS commits.
   assign pair_word = {neg_hold, pos_snap_p0};
   assign asm_cat   = {pair_word, asm_q};
   assign word_next = asm_cat[WORD_W+PAIR_W-1:PAIR_W];
   assign word_done = pend_p0 && (pair_idx == IDX_W'(PAIRS - 1));
   assign word_load = word_done && (!out_valid || out_ready);
   assign word_drop = word_done && out_valid && !out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_idx <= '0;
         asm_q    <= '0;
      end else if (pend_p0) begin
         asm_q <= word_next;
         if (word_done) begin
            pair_idx <= '0;
         end else begin
            pair_idx <= pair_idx + 1'b1;
         end
      end
   end

   // Output register: a word arriving on an accepting edge replaces the old one without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out  <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (word_load) begin
            data_out  <= word_next;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (word_drop) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef DUAL_EDGE_DESER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (word_load) begin
            word_cnt <= word_cnt + 16'd1;
         end
         if (word_drop) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dual_edge_deser.sv
// Directed bench for dual_edge_deser (DATA_WIDTH=8, RATIO=4) with hand-computed words.
module tb_dual_edge_deser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  data_in = '0;
   logic [7:0]  pos_edge_latch_en = 8'hFF;
   logic [7:0]  neg_edge_latch_en = 8'hFF;
   logic [31:0] data_out;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        overflow;
`ifdef DUAL_EDGE_DESER_STATS_EN
   logic [15:0] word_cnt;
   logic [15:0] drop_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   dual_edge_deser #(.DATA_WIDTH(8), .RATIO(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .data_in           (data_in),
      .pos_edge_latch_en (pos_edge_latch_en),
      .neg_edge_latch_en (neg_edge_latch_en),
      .data_out          (data_out),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .overflow          (overflow)
`ifdef DUAL_EDGE_DESER_STATS_EN
      ,
      .word_cnt          (word_cnt),
      .drop_cnt          (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives one posedge sample (with in_valid) then one negedge sample; ends just after the negedge.
   task automatic send_pair(input logic [7:0] p, input logic [7:0] n, input logic v);
      data_in  = p;
      in_valid = v;
      @(posedge clk);
      #2;
      data_in  = n;
      in_valid = 1'b0;
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      #2;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_data_out", data_out, 0);
      check_eq("rst_overflow", overflow, 0);
`ifdef DUAL_EDGE_DESER_STATS_EN
      check_eq("rst_word_cnt", word_cnt, 0);
      check_eq("rst_drop_cnt", drop_cnt, 0);
`endif
      do_reset();

      // Basic word, consumer always ready
      out_ready = 1'b1;
      send_pair(8'h11, 8'h22, 1'b1);
      send_pair(8'h33, 8'h44, 1'b1);
      check_eq("t1_not_yet", out_valid, 0);
      @(posedge clk); #1;
      check_eq("t1_valid", out_valid, 1);
      check_eq("t1_data", data_out, 32'h44332211);
      @(posedge clk); #1;
      check_eq("t1_valid_low", out_valid, 0);
      @(negedge clk); #2;

      // Masked posedge capture: upper nibble repeats preloaded 0xA
      send_pair(8'hA0, 8'h00, 1'b0);
      pos_edge_latch_en = 8'h0F;
      send_pair(8'h11, 8'h22, 1'b1);
      send_pair(8'h33, 8'h44, 1'b1);
      @(posedge clk); #1;
      check_eq("t2_valid", out_valid, 1);
      check_eq("t2_data", data_out, 32'h44A322A1);
      pos_edge_latch_en = 8'hFF;
      @(negedge clk); #2;

      // Backpressure: three words, only the first kept
      out_ready = 1'b0;
      do_reset();
      send_pair(8'h01, 8'h02, 1'b1);
      send_pair(8'h03, 8'h04, 1'b1);
      send_pair(8'h05, 8'h06, 1'b1);
      check_eq("t3_w1_valid", out_valid, 1);
      check_eq("t3_w1_data", data_out, 32'h04030201);
      check_eq("t3_w1_no_ovf", overflow, 0);
      send_pair(8'h07, 8'h08, 1'b1);
      send_pair(8'h09, 8'h0A, 1'b1);
      check_eq("t3_w2_ovf", overflow, 1);
      send_pair(8'h0B, 8'h0C, 1'b1);
      @(posedge clk); #1;
      check_eq("t3_hold_valid", out_valid, 1);
      check_eq("t3_hold_data", data_out, 32'h04030201);
      check_eq("t3_ovf_sticky", overflow, 1);
`ifdef DUAL_EDGE_DESER_STATS_EN
      check_eq("t3_word_cnt", word_cnt, 1);
      check_eq("t3_drop_cnt", drop_cnt, 2);
`endif
      @(negedge clk); #2;

      // Completion on the same edge the old word is accepted
      do_reset();
      check_eq("t4_rst_ovf", overflow, 0);
      send_pair(8'h21, 8'h22, 1'b1);
      send_pair(8'h23, 8'h24, 1'b1);
      send_pair(8'h31, 8'h32, 1'b1);
      check_eq("t4_w1_valid", out_valid, 1);
      check_eq("t4_w1_data", data_out, 32'h24232221);
      send_pair(8'h33, 8'h34, 1'b1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("t4_w2_valid", out_valid, 1);
      check_eq("t4_w2_data", data_out, 32'h34333231);
      check_eq("t4_no_ovf", overflow, 0);
      @(posedge clk); #1;
      check_eq("t4_drain", out_valid, 0);
      @(negedge clk); #2;

      // Asynchronous reset after one committed pair discards the partial word
      send_pair(8'h55, 8'h66, 1'b1);
      send_pair(8'h77, 8'h88, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("t5_async_valid", out_valid, 0);
      check_eq("t5_async_data", data_out, 0);
      check_eq("t5_async_ovf", overflow, 0);
      #1;
      rst_n = 1'b1;
      send_pair(8'h91, 8'h92, 1'b1);
      send_pair(8'h93, 8'h94, 1'b1);
      check_eq("t5_no_early", out_valid, 0);
      @(posedge clk); #1;
      check_eq("t5_valid", out_valid, 1);
      check_eq("t5_data", data_out, 32'h94939291);
      @(negedge clk); #2;

      // in_valid 1,0,0,1: pair index holds across the gap
      send_pair(8'hC1, 8'hC2, 1'b1);
      send_pair(8'hE1, 8'hE2, 1'b0);
      send_pair(8'hE3, 8'hE4, 1'b0);
      check_eq("t6_gap_quiet", out_valid, 0);
      send_pair(8'hD1, 8'hD2, 1'b1);
      check_eq("t6_gap_quiet2", out_valid, 0);
      @(posedge clk); #1;
      check_eq("t6_valid", out_valid, 1);
      check_eq("t6_data", data_out, 32'hD2D1C2C1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dual_edge_deser.md
Name: dual_edge_deser

Overview:
- Parametrised successor to the 8-bit dual-edge flip-flop. Captures a DATA_WIDTH-bit bus on both clock edges, with per-bit pos/neg latch enables.
- Packs consecutive edge samples into RATIO-sample words and presents them on a valid/ready output register.
- Sits between a DDR-style source interface and the single-edge core fabric. It replaces ad-hoc negedge capture logic.

Parameters:
- DATA_WIDTH, 8, bits per edge sample; must be at least 1.
- RATIO, 4, samples per output word; must be even and at least 2. The block collects RATIO/2 pairs per word.

Ports:
- clk  input  1  sole clock; both edges used.
- rst_n  input  1  asynchronous active-low reset; clears all state, including negedge registers.
- in_valid  input  1  sampled at posedge k; qualifies the pair (posedge k sample, negedge k sample).
- data_in  input  DATA_WIDTH  edge-sampled data.
- pos_edge_latch_en  input  DATA_WIDTH  per-bit posedge capture enable.
- neg_edge_latch_en  input  DATA_WIDTH  per-bit negedge capture enable.
- data_out  output  DATA_WIDTH*RATIO  packed word; sample 0 (earliest) in bits [DATA_WIDTH-1:0].
- out_valid  output  1  data_out holds an unaccepted word.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high at a posedge.
- overflow  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): pos_hold=0, neg_hold=0, pair-pending=0, pair index=0, assembly shift register=0, data_out=0, out_valid=0, overflow=0. Any partial word is discarded. First capture happens at the first posedge after deassertion.
- Edge capture:
  - pos_hold[i] loads data_in[i] at every posedge where pos_edge_latch_en[i]=1; otherwise it holds.
  - neg_hold[i] behaves the same at negedges, gated by neg_edge_latch_en[i].
  - Both update independently of in_valid.
  - The posedge sample is pos_hold after the posedge update; the negedge sample is neg_hold after the negedge update. A disabled bit therefore repeats its last captured value.
- Pair commit:
  - in_valid=1 at posedge k sets pending and snapshots the posedge-k sample.
  - At posedge k+1, if pending is set: append {neg sample of negedge k, pos sample of posedge k} to the assembly register, pos sample first (lower slice), then increment the pair index.
  - pending is reloaded from in_valid at the same edge, so back-to-back pairs run at full rate with no bubbles.
- Word completion, when the pair index reaches RATIO/2 at a commit:
  - If out_valid=0, or out_valid=1 with out_ready=1 at that same edge: load data_out, set out_valid=1, reset the pair index to 0.
  - Otherwise: drop the word, set overflow=1, reset the pair index to 0. data_out keeps the old word.
- Latency: the last pair is qualified at posedge k, committed at posedge k+1, and out_valid is high from posedge k+1.
- Handshake:
  - out_valid falls at a posedge where out_ready=1, unless a new word loads at that edge; then it stays high with the new data.
  - data_out is stable while out_valid=1 and out_ready=0.
- overflow clears only on reset.
- in_valid gaps: the pair index holds across gaps, and partial words persist indefinitely.

Optional Feature:
- Macro: DUAL_EDGE_DESER_STATS_EN.
- Defined: adds outputs word_cnt[15:0] and drop_cnt[15:0], both reset to 0 and wrapping modulo 2^16.
  - word_cnt increments on each word loaded into data_out.
  - drop_cnt increments on each dropped word.
  - On a drop, both the overflow update and the drop_cnt increment happen at the same edge.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan (DATA_WIDTH=8, RATIO=4):
- Data 0x11@pos k, 0x22@neg k, 0x33@pos k+1, 0x44@neg k+1; enables 0xFF; in_valid=1 at k and k+1; out_ready=1 -> data_out=0x44332211, out_valid=1 from posedge k+2, low after posedge k+3.
- Same stimulus with pos_edge_latch_en=0x0F, pos_hold preloaded to 0xA0 -> posedge samples 0xA1 and 0xA3; data_out=0x44A322A1.
- out_ready=0, feed three full words continuously -> first word held stable, out_valid=1, overflow=1 after the second word completes; with STATS_EN, drop_cnt=2 and word_cnt=1.
- Word completes at the same posedge where out_ready=1 with out_valid=1 -> new word loads, out_valid stays 1, overflow stays 0.
- Assert rst_n low between negedge and posedge after one committed pair -> all outputs 0 immediately; the next word packs only post-reset samples.
- in_valid pattern 1,0,0,1 (pairs A then B) -> one word {B,A} once B commits; no word emitted during the gap.
